mips_multicycle_controller: RTL
===============================

MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL have no parameters; encodings below are fixed.
REQ-002 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-003 SHALL have: Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
REQ-004 SHALL have: Op  in  6  instruction[31:26]; Funct  in  6  instruction[5:0].
REQ-005 SHALL have: Zero  in  1  ALU zero flag; MemReady  in  1  memory access completes this cycle.
REQ-006 SHALL have outputs (1 bit): IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal.
REQ-007 SHALL have outputs: ALUSrcB  2; PCSrc  2; ALUControl  3; State  4 (debug); Retired  32 (instructions completed).

Function
REQ-008 SHALL be a 12-state FSM, encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTE=6 ALUWB=7 BEQ=8 ADDIEX=9 ADDIWB=10 JUMP=11; unused codes -> FETCH next cycle.
REQ-009 SHALL drive State = current state register.
REQ-010 SHALL drive each control output from current state only (except PCEn, IRWrite); any output not listed for a state = 0.
REQ-011 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00; IRWrite=PCWrite=MemReady; next = DECODE if MemReady else FETCH.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, add; next by Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BEQ, 001000->ADDIEX, 000010->JUMP, else FETCH.
REQ-013 DECODE with unsupported Op SHALL assert Illegal for that one cycle; Illegal=0 in every other state.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, add; next MEMRD if Op=100011 else MEMWR.
REQ-015 MEMRD: IorD=1; stay until MemReady=1, then MEMWB.
REQ-016 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-017 MEMWR: IorD=1, MemWrite=1 held every cycle in state; stay until MemReady=1, then FETCH.
REQ-018 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct; next ALUWB.
REQ-019 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-020 BEQ: ALUSrcA=1, ALUSrcB=00, subtract, PCSrc=01, Branch=1; next FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, add; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-022 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-023 PCEn SHALL = PCWrite OR (Branch AND Zero), combinational same cycle.
REQ-024 ALUControl: add=010, subtract=110; in EXECUTE Funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-025 Retired SHALL increment by 1 on each clock edge leaving MEMWB, ALUWB, BEQ, ADDIWB, JUMP, or leaving MEMWR with MemReady=1; wraps 0xFFFFFFFF->0; not incremented on Illegal.
REQ-026 Instruction latencies with MemReady=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-027 Reset=0 SHALL immediately (no clock) force State=FETCH and Retired=0, in any state.
REQ-028 While Reset=0, IRWrite, PCEn, RegWrite, MemWrite, Illegal SHALL be 0 regardless of MemReady/Zero.
REQ-029 After Reset rises, first rising edge evaluates FETCH normally.

Verification
REQ-030 lw, MemReady=1: State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; Retired 0->1.
REQ-031 beq with Zero=1 -> PCEn=1, PCSrc=01 in state 8; repeat with Zero=0 -> PCEn=0; Retired increments both times.
REQ-032 R-type Funct=100010: ALUControl=110 in state 6; RegDst=1, RegWrite=1 in state 7.
REQ-033 FETCH with MemReady=0 for 3 cycles: State stays 0, IRWrite=PCEn=0; MemReady=1 -> IRWrite=PCEn=1, next State=1.
REQ-034 Op=111111: Illegal=1 in state 1, next State=0, Retired unchanged.
REQ-035 sw stalled in MEMWR (MemReady=0), Reset driven 0 asynchronously: State=0, MemWrite=0, Retired=0 before next Clk edge.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: a 12-state FSM that sequences fetch, decode
// and execute of lw, sw, R-type, addi, beq and j. It drives the datapath
// control lines and counts retired instructions.
module mips_multicycle_controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCEn,
    output logic        Illegal,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State,
    output logic [31:0] Retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // Raw strobes before the reset gate, plus internal PC/branch controls.
    logic ir_write;
    logic mem_write;
    logic reg_write;
    logic illegal;
    logic pc_write;
    logic branch;
    logic retire;

    // State register; reset returns to FETCH without waiting for a clock.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = FETCH;
        IorD       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        reg_write  = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ir_write   = MemReady;
                pc_write   = MemReady;
                state_d    = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                retire    = MemReady;
                state_d   = MemReady ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100000: ALUControl = ALU_ADD;
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write-type strobes are forced low while reset is held, whatever the
    // memory and ALU flags are doing.
    assign IRWrite  = Reset & ir_write;
    assign MemWrite = Reset & mem_write;
    assign RegWrite = Reset & reg_write;
    assign Illegal  = Reset & illegal;
    assign PCEn     = Reset & (pc_write | (branch & Zero));
    assign State    = state_q;

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Retired <= 32'd0;
        end else if (retire) begin
            Retired <= Retired + 32'd1;
        end
    end

endmodule
